// File: rtl/unstripe_pkg.sv
// Shared definitions for the two-lane unstriping scheduler.
//   BYTE_W  : lane and output byte width
//   state_t : scheduler states IDLE / ALIGN / RUN / FLUSH
package unstripe_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane elastic buffer (DEPTH x BYTE_W) absorbing inter-lane arrival skew.
// Ports:
//   clk_2f : byte clock
//   reset  : asynchronous, active-low reset (pointers only)
//   flush  : empties the buffer; wins over wr/rd
//   wr/din : write strobe and byte; accepted when not full, or when full
//            and a read happens in the same cycle
//   rd     : pop the head entry (ignored when empty)
//   dout   : head entry, combinational from the storage array
//   full   : DEPTH entries held
//   empty  : no entries held
module lane_fifo
  import unstripe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr,
  input  logic [BYTE_W-1:0] din,
  input  logic              rd,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [BYTE_W-1:0] mem [DEPTH];
  logic              rd_ok;
  logic              wr_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok = rd && !empty;
  // A write into a full buffer is fine when the head leaves in the same cycle.
  assign wr_ok = wr && (!full || rd_ok);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is data only; it needs no reset since the pointers define validity.
  always_ff @(posedge clk_2f) begin
    if (wr_ok && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/unstripe_lane_sched.sv
// Two-lane unstriping scheduler. Each lane feeds its own elastic buffer; bytes
// are popped in strict lane order 0,1,0,1... onto one valid/ready byte stream.
// Starvation of the selected lane and buffer overflow both trigger a one-cycle
// FLUSH followed by realignment.
// Ports:
//   clk_2f    : byte clock
//   reset     : asynchronous, active-low reset
//   enable    : scheduler enable; low returns to IDLE, flushes, clears errors
//   lane_0/1  : lane bytes, qualified by valid_0/1
//   out_ready : consumer accepts data_out this cycle
//   data_out  : registered unstriped byte, qualified by valid_out
//   aligned   : high while in RUN (registered)
//   err_skew  : sticky starvation timeout flag
//   err_ovf   : sticky lane buffer overflow flag
module unstripe_lane_sched
  import unstripe_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SKEW_MAX = 8
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              enable,
  input  logic [BYTE_W-1:0] lane_0,
  input  logic              valid_0,
  input  logic [BYTE_W-1:0] lane_1,
  input  logic              valid_1,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              aligned,
  output logic              err_skew,
  output logic              err_ovf
);

  localparam int CW = $clog2(SKEW_MAX + 1);
  localparam logic [CW-1:0] SKEW_LIM = CW'(SKEW_MAX);
  localparam logic [CW-1:0] SKEW_ONE = CW'(1);

  state_t            state;
  logic              sel;
  logic [CW-1:0]     skew_cnt;

  logic              wr_open;
  logic              flush_buf;
  logic              wr_0;
  logic              wr_1;
  logic              rd_0;
  logic              rd_1;
  logic              full_0;
  logic              full_1;
  logic              empty_0;
  logic              empty_1;
  logic [BYTE_W-1:0] dout_0;
  logic [BYTE_W-1:0] dout_1;
  logic [BYTE_W-1:0] head;
  logic              sel_empty;
  logic              oth_empty;
  logic              pop;
  logic              ovf;
  logic              starved;
  logic              skew_hit;

  // Buffers take writes only while the scheduler is collecting or running.
  assign wr_open   = enable && ((state == ALIGN) || (state == RUN));
  assign flush_buf = !enable || (state == FLUSH);
  assign wr_0      = wr_open && valid_0;
  assign wr_1      = wr_open && valid_1;

  assign sel_empty = sel ? empty_1 : empty_0;
  assign oth_empty = sel ? empty_0 : empty_1;
  assign head      = sel ? dout_1 : dout_0;

  // The output register can take a new byte when it is empty or being drained.
  assign pop  = enable && (state == RUN) && (!valid_out || out_ready) && !sel_empty;
  assign rd_0 = pop && !sel;
  assign rd_1 = pop && sel;

  assign ovf = (wr_0 && full_0 && !rd_0) || (wr_1 && full_1 && !rd_1);

  // Starved: the lane we must read next is empty while the other holds data.
  // Both empty is an idle link and is not counted.
  assign starved  = (state == RUN) && sel_empty && !oth_empty;
  assign skew_hit = starved && (skew_cnt >= (SKEW_LIM - SKEW_ONE));

  lane_fifo #(.DEPTH(DEPTH)) u_fifo_0 (
    .clk_2f (clk_2f),
    .reset  (reset),
    .flush  (flush_buf),
    .wr     (wr_0),
    .din    (lane_0),
    .rd     (rd_0),
    .dout   (dout_0),
    .full   (full_0),
    .empty  (empty_0)
  );

  lane_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
    .clk_2f (clk_2f),
    .reset  (reset),
    .flush  (flush_buf),
    .wr     (wr_1),
    .din    (lane_1),
    .rd     (rd_1),
    .dout   (dout_1),
    .full   (full_1),
    .empty  (empty_1)
  );

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      skew_cnt  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      aligned   <= 1'b0;
      err_skew  <= 1'b0;
      err_ovf   <= 1'b0;
    end else if (!enable) begin
      state     <= IDLE;
      sel       <= 1'b0;
      skew_cnt  <= '0;
      valid_out <= 1'b0;
      aligned   <= 1'b0;
      err_skew  <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= ALIGN;
        end

        ALIGN: begin
          if (ovf) begin
            err_ovf <= 1'b1;
            state   <= FLUSH;
          end else if (!empty_0 && !empty_1) begin
            state   <= RUN;
            sel     <= 1'b0;
            aligned <= 1'b1;
          end
        end

        RUN: begin
          if (pop) begin
            data_out  <= head;
            valid_out <= 1'b1;
            sel       <= ~sel;
            skew_cnt  <= '0;
          end else if (out_ready) begin
            valid_out <= 1'b0;
          end

          if (skew_hit) begin
            skew_cnt <= SKEW_LIM;
            err_skew <= 1'b1;
            state    <= FLUSH;
            aligned  <= 1'b0;
          end else if (starved) begin
            skew_cnt <= skew_cnt + SKEW_ONE;
          end

          if (ovf) begin
            err_ovf <= 1'b1;
            state   <= FLUSH;
            aligned <= 1'b0;
          end
        end

        FLUSH: begin
          valid_out <= 1'b0;
          sel       <= 1'b0;
          skew_cnt  <= '0;
          aligned   <= 1'b0;
          state     <= ALIGN;
        end

        default: begin
          state   <= IDLE;
          aligned <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unstripe_lane_sched.sv
// Directed bench for unstripe_lane_sched (DEPTH=4, SKEW_MAX=8).
module tb_unstripe_lane_sched;

  logic       clk_2f = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] lane_0;
  logic       valid_0;
  logic [7:0] lane_1;
  logic       valid_1;
  logic       out_ready;
  logic [7:0] data_out;
  logic       valid_out;
  logic       aligned;
  logic       err_skew;
  logic       err_ovf;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic [7:0] got[$];
  int         got_t[$];

  unstripe_lane_sched #(.DEPTH(4), .SKEW_MAX(8)) dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .enable    (enable),
    .lane_0    (lane_0),
    .valid_0   (valid_0),
    .lane_1    (lane_1),
    .valid_1   (valid_1),
    .out_ready (out_ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .aligned   (aligned),
    .err_skew  (err_skew),
    .err_ovf   (err_ovf)
  );

  always #5 clk_2f = ~clk_2f;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: drive inputs, log any transfer happening at this edge, then
  // leave the bench 1 time unit after the edge.
  task automatic step(input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1, input logic rdy);
    valid_0   = v0;
    lane_0    = d0;
    valid_1   = v1;
    lane_1    = d1;
    out_ready = rdy;
    if (valid_out === 1'b1 && out_ready === 1'b1) begin
      got.push_back(data_out);
      got_t.push_back(cyc);
    end
    @(posedge clk_2f);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 8'h00, 1'b0, 8'h00, rdy);
  endtask

  // enable low for one cycle (IDLE + flush + error clear), then back to ALIGN.
  task automatic restart();
    enable = 1'b0;
    idle(1'b1);
    enable = 1'b1;
    idle(1'b1);
    got.delete();
    got_t.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; valid_0 = 1'b0; valid_1 = 1'b0;
    lane_0 = 8'h00; lane_1 = 8'h00; out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({data_out, valid_out, aligned, err_skew, err_ovf} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h v=%b al=%b es=%b eo=%b want all 0",
               data_out, valid_out, aligned, err_skew, err_ovf);
    end
    @(posedge clk_2f);
    @(posedge clk_2f);
    #3 reset = 1'b1;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic test_same_cycle();
    logic [7:0] exp[4];
    exp = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    restart();
    step(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
    step(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1);
    n_checks++;
    if (aligned !== 1'b1) begin
      n_err++;
      $display("FAIL t1_aligned: got %b want 1", aligned);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== exp[i]) begin
        n_err++;
        $display("FAIL t1_byte%0d: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, exp[i]);
      end
    end
    idle(1'b1);
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL t1_drain: got valid_out=%b want 0", valid_out);
    end
  endtask

  task automatic test_lag();
    logic [7:0] exp[4];
    exp = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    restart();
    step(1'b1, 8'hA0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hA1, 1'b0, 8'h00, 1'b1);
    idle(1'b1);
    step(1'b0, 8'h00, 1'b1, 8'hB0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'hB1, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    n_checks++;
    if (got.size() != 4) begin
      n_err++;
      $display("FAIL t2_count: got %0d bytes want 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] g;
      g = (i < got.size()) ? got[i] : 8'hxx;
      n_checks++;
      if (g !== exp[i]) begin
        n_err++;
        $display("FAIL t2_byte%0d: got %h want %h", i, g, exp[i]);
      end
    end
    n_checks++;
    if (got.size() == 4 && (got_t[3] - got_t[0]) != 3) begin
      n_err++;
      $display("FAIL t2_gapless: got span %0d cycles want 3", got_t[3] - got_t[0]);
    end
    n_checks++;
    if (err_skew !== 1'b0 || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL t2_status: got es=%b al=%b want es=0 al=1", err_skew, aligned);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[8];
    exp = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
    restart();
    for (int i = 0; i < 4; i++)
      step(1'b1, 8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i), 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 8'hB0) begin
        n_err++;
        $display("FAIL t3_hold%0d: got v=%b d=%h want v=1 d=b0", i, valid_out, data_out);
      end
    end
    for (int i = 0; i < 10; i++) idle(1'b1);
    n_checks++;
    if (got.size() != 8) begin
      n_err++;
      $display("FAIL t3_count: got %0d bytes want 8", got.size());
    end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] g;
      g = (i < got.size()) ? got[i] : 8'hxx;
      n_checks++;
      if (g !== exp[i]) begin
        n_err++;
        $display("FAIL t3_byte%0d: got %h want %h", i, g, exp[i]);
      end
    end
  endtask

  task automatic test_starve();
    logic [7:0] exp[5];
    exp = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2};
    restart();
    step(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);   // k0
    step(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1);   // k1 -> RUN
    step(1'b1, 8'hA2, 1'b0, 8'h00, 1'b1);   // k2
    step(1'b1, 8'hA3, 1'b0, 8'h00, 1'b1);   // k3
    for (int k = 4; k <= 15; k++) begin
      idle(1'b1);
      if (k == 13) begin
        n_checks++;
        if (err_skew !== 1'b0) begin
          n_err++;
          $display("FAIL t4_early: got err_skew=%b after 7 starved cycles want 0", err_skew);
        end
      end
      if (k == 14) begin
        n_checks++;
        if (err_skew !== 1'b1 || aligned !== 1'b0) begin
          n_err++;
          $display("FAIL t4_timeout: got es=%b al=%b want es=1 al=0", err_skew, aligned);
        end
      end
    end
    n_checks++;
    if (got.size() != 5) begin
      n_err++;
      $display("FAIL t4_count: got %0d bytes want 5", got.size());
    end
    for (int i = 0; i < 5; i++) begin
      logic [7:0] g;
      g = (i < got.size()) ? got[i] : 8'hxx;
      n_checks++;
      if (g !== exp[i]) begin
        n_err++;
        $display("FAIL t4_byte%0d: got %h want %h", i, g, exp[i]);
      end
    end
    got.delete();
    got_t.delete();
    step(1'b1, 8'hC0, 1'b1, 8'hD0, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);
    n_checks++;
    if (got.size() != 2 || got[0] !== 8'hC0 || got[1] !== 8'hD0) begin
      n_err++;
      $display("FAIL t4_resume: got %0d bytes first=%h want C0,D0", got.size(),
               (got.size() > 0) ? got[0] : 8'hxx);
    end
    n_checks++;
    if (err_skew !== 1'b1 || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL t4_sticky: got es=%b al=%b want es=1 al=1", err_skew, aligned);
    end
  endtask

  // Leaves the block in RUN with E0 on data_out and err_ovf set.
  task automatic test_overflow();
    restart();
    for (int k = 0; k <= 4; k++) begin
      step(1'b1, 8'h50 + 8'(k), 1'b0, 8'h00, 1'b0);
      if (k == 3) begin
        n_checks++;
        if (err_ovf !== 1'b0) begin
          n_err++;
          $display("FAIL t5_early: got err_ovf=%b with buffer just full want 0", err_ovf);
        end
      end
    end
    n_checks++;
    if (err_ovf !== 1'b1 || aligned !== 1'b0 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL t5_ovf: got eo=%b al=%b v=%b want eo=1 al=0 v=0", err_ovf, aligned, valid_out);
    end
    idle(1'b0);                              // FLUSH -> ALIGN
    step(1'b1, 8'hE0, 1'b1, 8'hE1, 1'b0);
    idle(1'b0);                              // ALIGN -> RUN
    idle(1'b1);                              // pop lane 0
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 8'hE0 || err_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL t5_flushed: got v=%b d=%h eo=%b want v=1 d=e0 eo=1", valid_out, data_out, err_ovf);
    end
  endtask

  task automatic test_reset_mid_run();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({data_out, valid_out, aligned, err_skew, err_ovf} !== 12'h000) begin
      n_err++;
      $display("FAIL t6_async: got data=%h v=%b al=%b es=%b eo=%b want all 0",
               data_out, valid_out, aligned, err_skew, err_ovf);
    end
    @(posedge clk_2f);
    #3 reset = 1'b1;
    enable = 1'b1;
    @(posedge clk_2f);                       // IDLE -> ALIGN
    #1;
    got.delete();
    got_t.delete();
    step(1'b1, 8'hF0, 1'b1, 8'hF1, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);
    n_checks++;
    if (got.size() != 2 || got[0] !== 8'hF0 || got[1] !== 8'hF1) begin
      n_err++;
      $display("FAIL t6_realign: got %0d bytes first=%h want F0,F1", got.size(),
               (got.size() > 0) ? got[0] : 8'hxx);
    end
    n_checks++;
    if (err_ovf !== 1'b0 || err_skew !== 1'b0 || aligned !== 1'b1) begin
      n_err++;
      $display("FAIL t6_status: got eo=%b es=%b al=%b want 0 0 1", err_ovf, err_skew, aligned);
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_lag();
    test_backpressure();
    test_starve();
    test_overflow();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
